// File: rtl/vdma_pkg.sv
// Shared types and constants for the video DMA write burst scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: scheduler state encoding, AXI 4 KB boundary size, BRESP codes.
package vdma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ISSUE = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int AXI_4K = 4096;

   localparam logic [1:0] BRESP_OKAY   = 2'd0;
   localparam logic [1:0] BRESP_SLVERR = 2'd2;
   localparam logic [1:0] BRESP_DECERR = 2'd3;

endpackage

// File: rtl/vdma_burst_split.sv
// Picks the length of the next AXI burst: min(remaining, MAX_BURST, beats to next 4 KB line).
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the scheduler is in its CALC cycle.
//
// Ports:
//   addr      - burst start byte address (only bits [11:0] matter)
//   remaining - beats still to issue for the current segment (>= 1)
//   len       - beats in the next burst, 1..MAX_BURST
module vdma_burst_split
   import vdma_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int LEN_WIDTH      = 16,
   parameter int BYTES_PER_BEAT = 4,
   parameter int MAX_BURST      = 256
)
(
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [LEN_WIDTH-1:0]  remaining,
   output logic [8:0]            len
);

   localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
   // Common compare width large enough for both the 4 KB room and the segment length.
   localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

   logic [12:0]   room_bytes;
   logic [12:0]   room_beats;
   logic [CW-1:0] cap;
   logic [CW-1:0] rem_w;
   logic [CW-1:0] len_w;
   logic          unused_addr_hi;

   // Upper address bits never influence the 4 KB room.
   assign unused_addr_hi = ^addr[ADDR_WIDTH-1:12];

   always_comb begin
      // Room is 1..4096 bytes; a 4096 result means the address sits exactly on a 4 KB line.
      room_bytes = 13'(AXI_4K) - {1'b0, addr[11:0]};
      room_beats = room_bytes >> BEAT_SHIFT;
      cap        = (CW'(room_beats) < CW'(MAX_BURST)) ? CW'(room_beats) : CW'(MAX_BURST);
      rem_w      = CW'(remaining);
      len_w      = (rem_w < cap) ? rem_w : cap;
      len        = 9'(len_w);
   end

endmodule

// File: rtl/vdma_wr_burst_sched.sv
// Splits capture-buffer drain segments into 4 KB-safe AXI write bursts inside a frame ring.
// Latency: segment handshake -> first cmd_valid in 2 cycles; at most one command per 2 cycles.
// Backpressure: seg_ready only in IDLE; cmd_valid holds until cmd_ready, and is withheld at MAX_OUTSTANDING.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   cfg_enable/base/stride        - segment acceptance enable, frame 0 base, frame stride (bytes)
//   rd_frame_idx                  - frame held by the display reader; never becomes the write frame
//   seg_valid/ready/beats/eof     - segment request from the capture buffer
//   cmd_valid/ready/addr/len      - burst command to the AXI write master (len is AWLEN)
//   resp_valid/code               - one pulse per completed burst with its BRESP
//   wr_frame_idx, last_frame_idx  - frame being written, last completed frame
//   frame_done, frame_skip_cnt    - frame completion pulse, saturating count of blocked ring advances
//   err, busy                     - sticky error on non-OKAY BRESP, activity indicator
module vdma_wr_burst_sched
   import vdma_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int BYTES_PER_BEAT  = 4,
   parameter int MAX_BURST       = 256,
   parameter int MAX_OUTSTANDING = 4,
   parameter int NUM_FRAMES      = 3
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_enable,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0] cfg_frame_stride,
   input  logic [2:0]            rd_frame_idx,
   input  logic                  seg_valid,
   output logic                  seg_ready,
   input  logic [LEN_WIDTH-1:0]  seg_beats,
   input  logic                  seg_eof,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [7:0]            cmd_len,
   input  logic                  resp_valid,
   input  logic [1:0]            resp_code,
   output logic [2:0]            wr_frame_idx,
   output logic                  frame_done,
   output logic [2:0]            last_frame_idx,
   output logic [15:0]           frame_skip_cnt,
   output logic                  err,
   output logic                  busy
);

   localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
   localparam int OW         = $clog2(MAX_OUTSTANDING + 1);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] frame_base;
   logic [ADDR_WIDTH-1:0] burst_addr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic                  eof_q;
   logic [8:0]            cur_len;
   logic [8:0]            split_len;
   logic [OW-1:0]         outstanding;
   logic                  cmd_fire;
   logic                  resp_take;
   logic                  last_burst;
   logic                  drain_done;
   logic [2:0]            next_frame;

   // Address of the next burst, sampled only in CALC so cfg changes land on a burst boundary.
   assign frame_base = cfg_base_addr + ADDR_WIDTH'(wr_frame_idx) * cfg_frame_stride;
   assign burst_addr = frame_base + offset;

   vdma_burst_split #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .LEN_WIDTH      (LEN_WIDTH),
      .BYTES_PER_BEAT (BYTES_PER_BEAT),
      .MAX_BURST      (MAX_BURST)
   ) u_burst_split (
      .addr      (burst_addr),
      .remaining (remaining),
      .len       (split_len)
   );

   assign cmd_fire   = cmd_valid && cmd_ready;
   // A stray response with nothing outstanding must not wrap the counter.
   assign resp_take  = resp_valid && (outstanding != '0);
   assign last_burst = (remaining == LEN_WIDTH'(cur_len));
   assign drain_done = (state == DRAIN) && (outstanding == '0);
   assign next_frame = (wr_frame_idx == 3'(NUM_FRAMES - 1)) ? 3'd0 : wr_frame_idx + 3'd1;
   assign busy       = (state != IDLE) || (outstanding != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      seg_ready = 1'b0;
      cmd_valid = 1'b0;
      case (state)
         IDLE: begin
            seg_ready = cfg_enable;
            if (seg_valid && cfg_enable) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            state_nxt = ISSUE;
         end
         ISSUE: begin
            cmd_valid = (outstanding < OW'(MAX_OUTSTANDING));
            if (cmd_valid && cmd_ready) begin
               state_nxt = last_burst ? DRAIN : CALC;
            end
         end
         DRAIN: begin
            if (outstanding == '0) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         offset         <= '0;
         remaining      <= '0;
         eof_q          <= 1'b0;
         cur_len        <= '0;
         outstanding    <= '0;
         cmd_addr       <= '0;
         cmd_len        <= '0;
         wr_frame_idx   <= '0;
         last_frame_idx <= '0;
         frame_done     <= 1'b0;
         frame_skip_cnt <= '0;
         err            <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (resp_valid && (resp_code != BRESP_OKAY)) begin
            err <= 1'b1;
         end

         // Simultaneous issue and retire cancel out.
         if (cmd_fire && !resp_take) begin
            outstanding <= outstanding + OW'(1);
         end else if (!cmd_fire && resp_take) begin
            outstanding <= outstanding - OW'(1);
         end

         if (state == IDLE && seg_valid && cfg_enable) begin
            remaining <= seg_beats;
            eof_q     <= seg_eof;
         end

         if (state == CALC) begin
            cmd_addr <= burst_addr;
            cmd_len  <= 8'(split_len - 9'd1);
            cur_len  <= split_len;
         end

         if (cmd_fire) begin
            offset    <= offset + (ADDR_WIDTH'(cur_len) << BEAT_SHIFT);
            remaining <= remaining - LEN_WIDTH'(cur_len);
         end

         // Frame completes only once every burst of its EOF segment is acknowledged.
         if (drain_done && eof_q) begin
            frame_done     <= 1'b1;
            last_frame_idx <= wr_frame_idx;
            offset         <= '0;
            if (next_frame == rd_frame_idx) begin
               // Reader holds the next frame: overwrite the current one instead.
               if (frame_skip_cnt != 16'hFFFF) begin
                  frame_skip_cnt <= frame_skip_cnt + 16'd1;
               end
            end else begin
               wr_frame_idx <= next_frame;
            end
         end
      end
   end

endmodule

// File: tb/tb_vdma_wr_burst_sched.sv
// Randomized scoreboard bench for vdma_wr_burst_sched plus a standalone check of vdma_burst_split.
// Latency: n/a.
// Backpressure: cmd_ready and B responses are randomly throttled or withheld.
module tb_vdma_wr_burst_sched;
   import vdma_pkg::*;

   localparam int AW  = 32;
   localparam int LW  = 16;
   localparam int BPB = 4;
   localparam int MB  = 256;
   localparam int MO  = 4;
   localparam int NF  = 3;
   localparam int SPLIT_MB = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_enable;
   logic [AW-1:0] cfg_base_addr;
   logic [AW-1:0] cfg_frame_stride;
   logic [2:0]    rd_frame_idx;
   logic          seg_valid;
   logic          seg_ready;
   logic [LW-1:0] seg_beats;
   logic          seg_eof;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic          resp_valid;
   logic [1:0]    resp_code;
   logic [2:0]    wr_frame_idx;
   logic          frame_done;
   logic [2:0]    last_frame_idx;
   logic [15:0]   frame_skip_cnt;
   logic          err;
   logic          busy;

   logic [AW-1:0] sp_addr;
   logic [LW-1:0] sp_rem;
   logic [8:0]    sp_len;

   always #5 clk = ~clk;

   vdma_wr_burst_sched #(
      .ADDR_WIDTH      (AW),
      .LEN_WIDTH       (LW),
      .BYTES_PER_BEAT  (BPB),
      .MAX_BURST       (MB),
      .MAX_OUTSTANDING (MO),
      .NUM_FRAMES      (NF)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_enable       (cfg_enable),
      .cfg_base_addr    (cfg_base_addr),
      .cfg_frame_stride (cfg_frame_stride),
      .rd_frame_idx     (rd_frame_idx),
      .seg_valid        (seg_valid),
      .seg_ready        (seg_ready),
      .seg_beats        (seg_beats),
      .seg_eof          (seg_eof),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_addr         (cmd_addr),
      .cmd_len          (cmd_len),
      .resp_valid       (resp_valid),
      .resp_code        (resp_code),
      .wr_frame_idx     (wr_frame_idx),
      .frame_done       (frame_done),
      .last_frame_idx   (last_frame_idx),
      .frame_skip_cnt   (frame_skip_cnt),
      .err              (err),
      .busy             (busy)
   );

   vdma_burst_split #(
      .ADDR_WIDTH     (AW),
      .LEN_WIDTH      (LW),
      .BYTES_PER_BEAT (BPB),
      .MAX_BURST      (SPLIT_MB)
   ) u_split (
      .addr      (sp_addr),
      .remaining (sp_rem),
      .len       (sp_len)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } cmd_t;

   cmd_t       exp_cmd_q[$];
   logic [2:0] exp_frame_q[$];

   int errors = 0;
   int checks = 0;

   int issued_cnt   = 0;
   int resp_cnt     = 0;
   int allowed_resp = 32'h3FFF_FFFF;
   int err_idx      = -1;
   int rdy_pct      = 100;
   int resp_pct     = 30;

   // Reference state: which frame is written, byte offset inside it, skips, sticky error.
   logic [2:0]    m_wr   = 3'd0;
   logic [AW-1:0] m_off  = '0;
   int            m_skip = 0;
   logic          m_err  = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Bursts = greedy cut of the segment at 256 beats and at every 4 KB line.
   task automatic model_seg(input int beats, input bit eof);
      logic [AW-1:0] a;
      int rem, room, len, nxt;
      cmd_t c;
      rem = beats;
      while (rem > 0) begin
         a    = cfg_base_addr + 32'(m_wr) * cfg_frame_stride + m_off;
         room = (4096 - int'(a % 4096)) / BPB;
         len  = rem;
         if (len > MB)   len = MB;
         if (len > room) len = room;
         c.addr = a;
         c.len  = 8'(len - 1);
         exp_cmd_q.push_back(c);
         m_off = m_off + 32'(len * BPB);
         rem   = rem - len;
      end
      if (eof) begin
         exp_frame_q.push_back(m_wr);
         nxt = (int'(m_wr) + 1) % NF;
         if (nxt == int'(rd_frame_idx)) begin
            if (m_skip < 65535) m_skip++;
         end else begin
            m_wr = 3'(nxt);
         end
         m_off = '0;
      end
   endtask

   task automatic send_seg(input int beats, input bit eof);
      int n;
      model_seg(beats, eof);
      @(negedge clk);
      seg_valid = 1'b1;
      seg_beats = LW'(beats);
      seg_eof   = eof;
      n = 0;
      while (!seg_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         errors++;
         checks++;
         $display("FAIL seg_handshake_timeout: seg_ready=%0d after %0d cycles, required 1", seg_ready, n);
      end
      @(posedge clk);
      #1;
      seg_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20000) begin
         errors++;
         $display("FAIL %s_idle_timeout: busy=%0d after %0d cycles, required 0", tag, busy, n);
      end
      @(negedge clk);
      check({tag, "_cmds_left"}, exp_cmd_q.size(), 0);
      check({tag, "_frames_left"}, exp_frame_q.size(), 0);
      check({tag, "_wr_frame_idx"}, wr_frame_idx, m_wr);
      check({tag, "_skip_cnt"}, frame_skip_cnt, m_skip);
      check({tag, "_err"}, err, m_err);
   endtask

   task automatic monitor();
      cmd_t c;
      logic [2:0] f;
      forever begin
         @(negedge clk);
         if (rst) begin
            issued_cnt = 0;
         end else begin
            if (cmd_valid && cmd_ready) begin
               // DUT outstanding right now = handshakes seen minus responses already consumed.
               check("outstanding_limit", (issued_cnt - resp_cnt + int'(resp_valid)) < MO, 1);
               if (exp_cmd_q.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL unexpected_cmd: addr=0x%0h len=%0d, required none", cmd_addr, cmd_len);
               end else begin
                  c = exp_cmd_q.pop_front();
                  check("cmd_addr", cmd_addr, c.addr);
                  check("cmd_len", cmd_len, c.len);
               end
               issued_cnt++;
            end
            if (frame_done) begin
               if (exp_frame_q.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL unexpected_frame_done: last_frame_idx=%0d, required no pulse", last_frame_idx);
               end else begin
                  f = exp_frame_q.pop_front();
                  check("last_frame_idx", last_frame_idx, f);
               end
            end
         end
      end
   endtask

   task automatic driver();
      forever begin
         @(posedge clk);
         #1;
         cmd_ready  = ($urandom_range(99) < rdy_pct);
         resp_valid = 1'b0;
         resp_code  = BRESP_OKAY;
         if (rst) begin
            resp_cnt = 0;
         end else if (issued_cnt > resp_cnt && resp_cnt < allowed_resp &&
                      $urandom_range(99) < resp_pct) begin
            resp_valid = 1'b1;
            resp_code  = (resp_cnt == err_idx) ? BRESP_SLVERR : BRESP_OKAY;
            resp_cnt++;
         end
      end
   endtask

   initial begin
      int base_issued;
      int exp_len;
      int room;
      int nsegs;

      rst              = 1'b1;
      cfg_enable       = 1'b1;
      cfg_base_addr    = 32'h1000_0000;
      cfg_frame_stride = 32'h0010_0000;
      rd_frame_idx     = 3'd7;
      seg_valid        = 1'b0;
      seg_beats        = '0;
      seg_eof          = 1'b0;
      cmd_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_code        = BRESP_OKAY;
      sp_addr          = '0;
      sp_rem           = '0;

      // Standalone split: 4 KB room vs MAX_BURST=64 vs remaining.
      for (int i = 0; i < 16; i++) begin
         sp_addr = $urandom & 32'hFFFF_FFFC;
         if (i == 0) begin
            sp_addr[11:0] = 12'h000;
            sp_rem        = 16'd1000;
         end else begin
            if (i % 2 == 1) sp_addr[11:2] = 10'h3FF - 10'($urandom_range(80));
            sp_rem = 16'($urandom_range(1, 300));
         end
         #1;
         room    = (4096 - int'(sp_addr % 4096)) / BPB;
         exp_len = int'(sp_rem);
         if (exp_len > SPLIT_MB) exp_len = SPLIT_MB;
         if (exp_len > room)     exp_len = room;
         check("split_len", sp_len, exp_len);
      end

      fork
         monitor();
         driver();
      join_none

      repeat (3) @(negedge clk);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_frame_idx", wr_frame_idx, 0);
      check("rst_last_frame_idx", last_frame_idx, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_skip_cnt", frame_skip_cnt, 0);
      check("rst_err", err, 0);
      rst = 1'b0;

      // Aligned single burst, one frame.
      send_seg(64, 1'b1);
      wait_idle("single");

      // Crossing a 4 KB line.
      cfg_base_addr = 32'h1000_0F00;
      send_seg(256, 1'b1);
      wait_idle("split4k");

      // Two segments make one frame; second continues at the first's end offset.
      cfg_base_addr = 32'h1000_0000;
      send_seg(32, 1'b0);
      send_seg(32, 1'b1);
      wait_idle("multiseg");

      // Outstanding limit with responses withheld.
      cfg_base_addr = 32'h2000_0000;
      allowed_resp  = resp_cnt;
      base_issued   = issued_cnt;
      send_seg(2048, 1'b1);
      repeat (30) @(negedge clk);
      check("hold_issued", issued_cnt - base_issued, MO);
      check("hold_cmd_valid", cmd_valid, 0);
      check("hold_busy", busy, 1);
      allowed_resp = allowed_resp + 1;
      repeat (10) @(negedge clk);
      check("one_resp_issued", issued_cnt - base_issued, MO + 1);
      allowed_resp = allowed_resp + 2;
      repeat (12) @(negedge clk);
      check("three_resp_issued", issued_cnt - base_issued, MO + 3);
      allowed_resp = 32'h3FFF_FFFF;
      wait_idle("outstanding");

      // SLVERR on the second burst of a segment; frame still completes, err stays set.
      rdy_pct  = 70;
      resp_pct = 50;
      err_idx  = resp_cnt + 1;
      m_err    = 1'b1;
      send_seg(600, 1'b1);
      wait_idle("slverr");
      err_idx = -1;
      send_seg(100, 1'b1);
      wait_idle("err_sticky");

      // Reset while the scheduler is issuing.
      allowed_resp = resp_cnt;
      send_seg(2048, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cmd_valid", cmd_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_wr_frame_idx", wr_frame_idx, 0);
      check("midrst_err", err, 0);
      check("midrst_skip_cnt", frame_skip_cnt, 0);
      exp_cmd_q.delete();
      exp_frame_q.delete();
      m_wr   = 3'd0;
      m_off  = '0;
      m_skip = 0;
      m_err  = 1'b0;
      rst = 1'b0;
      allowed_resp = 32'h3FFF_FFFF;
      @(negedge clk);

      // Ring with the reader parked on frame 2.
      cfg_base_addr    = 32'h3000_0000;
      cfg_frame_stride = 32'h0001_0000;
      rd_frame_idx     = 3'd2;
      for (int i = 0; i < 3; i++) begin
         send_seg($urandom_range(1, 300), 1'b1);
         wait_idle("ring");
      end

      // Random frames, configuration changed only between frames.
      for (int i = 0; i < 30; i++) begin
         rdy_pct  = $urandom_range(30, 100);
         resp_pct = $urandom_range(20, 100);
         cfg_base_addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(1023) << 2);
         cfg_frame_stride = $urandom & 32'h00FF_FFFC;
         rd_frame_idx = 3'($urandom_range(7));
         nsegs = $urandom_range(1, 3);
         for (int s = 0; s < nsegs; s++) begin
            send_seg($urandom_range(1, 600), (s == nsegs - 1));
         end
         wait_idle("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
